// File: rtl/i2c_pwm_pkg.sv
// Shared constants, FSM state encoding and helpers for the I2C-controlled LED PWM block.
package i2c_pwm_pkg;

  localparam int NUM_CH     = 8;
  localparam int PWM_PERIOD = 255;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

  // Element n is the power-up duty of channel n.
  localparam logic [NUM_CH-1:0][7:0] RESET_DUTY = {
    8'd255, 8'd200, 8'd100, 8'd80, 8'd60, 8'd40, 8'd20, 8'd1
  };

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_pwm_channel.sv
// One PWM channel: period-aligned shadow of the duty register, compare and output flop.
module i2c_pwm_channel
  import i2c_pwm_pkg::*;
#(
  parameter logic [7:0] RST_DUTY = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] duty,
  input  logic [7:0] count,
  output logic       pwm
);

  logic [7:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= RST_DUTY;
      pwm    <= 1'b0;
    end else begin
      if (load) shadow <= duty;
      pwm <= (count < shadow);
    end
  end

endmodule

// File: rtl/i2c_pwm_ctrl.sv
// 8-channel LED PWM controller with an oversampled I2C slave register port (SCL is not a clock).
// Define I2C_PWM_READBACK_EN to allow reading the duty registers back over I2C.
//   state        | meaning
//   ST_IDLE      | bus free, waiting for START
//   ST_ADDR      | shifting in address byte
//   ST_ADDR_ACK  | driving address ACK
//   ST_REG       | shifting in pointer byte
//   ST_REG_ACK   | driving pointer ACK
//   ST_WDATA     | shifting in duty data byte
//   ST_WDATA_ACK | driving data ACK
//   ST_RDATA     | driving duty[pointer] MSB first (readback build)
//   ST_RDATA_ACK | SDA released, sampling master ACK/NACK (readback build)
//   ST_IGNORE    | not addressed, waiting for START/STOP
module i2c_pwm_ctrl
  import i2c_pwm_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h42,
  parameter int         DIVIDER  = 1200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] pwm_out
);

  localparam int PW = $clog2(DIVIDER);

  logic [1:0] scl_sync, sda_sync;
  logic [2:0] scl_hist, sda_hist;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  i2c_state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] ptr, ptr_n;
  logic       sda_oe_n;
  logic       duty_we;
  logic       byte_done, addr_ok;
  logic [7:0] duty [NUM_CH];

  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic          tick, period_load;

  // Conditioning flops reset to the idle-bus level so release from reset is edge-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
      scl_f    <= majority3(scl_hist);
      sda_f    <= majority3(sda_hist);
      scl_q    <= scl_f;
      sda_q    <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & ~sda_f & sda_q;
  assign stop_det  = scl_f & scl_q & sda_f & ~sda_q;
  assign byte_done = (bit_cnt == 4'd8);

`ifdef I2C_PWM_READBACK_EN
  assign addr_ok = (shreg[7:1] == I2C_ADDR);
`else
  assign addr_ok = (shreg[7:1] == I2C_ADDR) && !shreg[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) duty[i] <= RESET_DUTY[i];
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      ptr     <= ptr_n;
      sda_oe  <= sda_oe_n;
      if (duty_we) duty[ptr] <= shreg;
    end
  end

  // All bus-side changes happen on filtered SCL edges; START/STOP override any state.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    duty_we   = 1'b0;
    if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_f};
            bit_cnt_n = bit_cnt + 1'b1;
          end else if (scl_fall && byte_done) begin
            sda_oe_n = 1'b1;
            if (state == ST_ADDR) begin
              if (addr_ok) begin
                state_n = ST_ADDR_ACK;
              end else begin
                state_n  = ST_IGNORE;
                sda_oe_n = 1'b0;
              end
            end else if (state == ST_REG) begin
              ptr_n   = shreg[2:0];
              state_n = ST_REG_ACK;
            end else begin
              duty_we = 1'b1;
              ptr_n   = ptr + 1'b1;
              state_n = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (state == ST_ADDR_ACK) state_n = ST_REG;
            else                      state_n = ST_WDATA;
`ifdef I2C_PWM_READBACK_EN
            // shreg still holds the address byte here; bit 0 is R/W.
            if (state == ST_ADDR_ACK && shreg[0]) begin
              state_n  = ST_RDATA;
              shreg_n  = duty[ptr];
              sda_oe_n = ~duty[ptr][7];
            end
`endif
          end
        end
`ifdef I2C_PWM_READBACK_EN
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 1'b1;
          end else if (scl_fall) begin
            if (byte_done) begin
              sda_oe_n = 1'b0;
              ptr_n    = ptr + 1'b1;
              state_n  = ST_RDATA_ACK;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise && sda_f) begin
            state_n = ST_IGNORE;
          end else if (scl_fall) begin
            state_n   = ST_RDATA;
            bit_cnt_n = '0;
            shreg_n   = duty[ptr];
            sda_oe_n  = ~duty[ptr][7];
          end
        end
`endif
        ST_IDLE, ST_IGNORE: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign tick        = (presc == PW'(DIVIDER - 1));
  assign period_load = tick && (pwm_cnt == 8'(PWM_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= period_load ? 8'd0 : pwm_cnt + 1'b1;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    i2c_pwm_channel #(
      .RST_DUTY(RESET_DUTY[n])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .load (period_load),
      .duty (duty[n]),
      .count(pwm_cnt),
      .pwm  (pwm_out[n])
    );
  end

endmodule

// File: tb/tb_i2c_pwm_ctrl.sv
// Directed bench for i2c_pwm_ctrl: bit-banged I2C master on an open-drain SDA model,
// PWM high-time measured over one full period per channel.
module tb_i2c_pwm_ctrl;

  localparam int DIV     = 4;
  localparam int PER_CLK = 255 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_oe;
  logic [7:0] pwm_out;

  int n_vec = 0;
  int n_err = 0;
  int hi_cnt [8];
  int exp_d  [8];
  logic       ack;
  logic [7:0] rd;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  i2c_pwm_ctrl #(
    .I2C_ADDR(7'h42),
    .DIVIDER (DIV)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .sda_oe (sda_oe),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    wt(6); sda_m = 1'b1;
    wt(6); scl_m = 1'b1;
    wt(6); sda_m = 1'b0;
    wt(6); scl_m = 1'b0;
  endtask

  task automatic i2c_stop;
    wt(6); sda_m = 1'b0;
    wt(6); scl_m = 1'b1;
    wt(6); sda_m = 1'b1;
    wt(12);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit rst_in_ack, output logic a);
    for (int i = 7; i >= 0; i--) begin
      wt(6); sda_m = b[i];
      wt(6); scl_m = 1'b1;
      wt(12); scl_m = 1'b0;
    end
    wt(6); sda_m = 1'b1;
    wt(6); scl_m = 1'b1;
    wt(6); a = sda_oe;
    if (rst_in_ack) begin
      rst = 1'b1;
      #1;
      chk_val("rst_sda_oe_now", sda_oe, 0);
    end
    wt(6); scl_m = 1'b0;
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      wt(6); sda_m = 1'b1;
      wt(6); scl_m = 1'b1;
      wt(6); b = {b[6:0], sda_i};
      wt(6); scl_m = 1'b0;
    end
    wt(6); sda_m = ~mack;
    wt(6); scl_m = 1'b1;
    wt(12); scl_m = 1'b0;
  endtask

  // Wait long enough for any pending shadow load, then count high clocks over one period.
  task automatic check_duties(input string tag);
    wt(PER_CLK + 10);
    for (int n = 0; n < 8; n++) hi_cnt[n] = 0;
    repeat (PER_CLK) begin
      @(negedge clk);
      for (int n = 0; n < 8; n++) if (pwm_out[n]) hi_cnt[n]++;
    end
    for (int n = 0; n < 8; n++)
      chk_val($sformatf("%s_ch%0d", tag, n), hi_cnt[n], exp_d[n] * DIV);
  endtask

  initial begin
    wt(5);
    chk_val("rst_sda_oe", sda_oe, 0);
    chk_val("rst_pwm", pwm_out, 0);
    rst = 1'b0;

    exp_d = '{1, 20, 40, 60, 80, 100, 200, 255};
    check_duties("dflt");
    chk_val("idle_sda_oe", sda_oe, 0);

    i2c_start;
    write_byte(8'h84, 1'b0, ack); chk_val("wr_addr_ack", ack, 1);
    write_byte(8'h03, 1'b0, ack); chk_val("wr_ptr_ack", ack, 1);
    write_byte(8'h00, 1'b0, ack); chk_val("wr_d0_ack", ack, 1);
    write_byte(8'h80, 1'b0, ack); chk_val("wr_d1_ack", ack, 1);
    i2c_stop;
    chk_val("stop_sda_oe", sda_oe, 0);
    exp_d = '{1, 20, 40, 0, 128, 100, 200, 255};
    check_duties("wr34");

    i2c_start;
    write_byte(8'h84, 1'b0, ack); chk_val("wrap_addr_ack", ack, 1);
    write_byte(8'h07, 1'b0, ack); chk_val("wrap_ptr_ack", ack, 1);
    write_byte(8'h10, 1'b0, ack); chk_val("wrap_d0_ack", ack, 1);
    write_byte(8'h20, 1'b0, ack); chk_val("wrap_d1_ack", ack, 1);
    i2c_stop;
    exp_d = '{32, 20, 40, 0, 128, 100, 200, 16};
    check_duties("wrap");

    i2c_start;
    write_byte(8'h86, 1'b0, ack); chk_val("bad_addr_nack", ack, 0);
    write_byte(8'h01, 1'b0, ack); chk_val("bad_ptr_nack", ack, 0);
    write_byte(8'h55, 1'b0, ack); chk_val("bad_data_nack", ack, 0);
    i2c_stop;
    check_duties("bad");

    i2c_start;
    write_byte(8'h84, 1'b0, ack); chk_val("rst_addr_ack", ack, 1);
    write_byte(8'h02, 1'b0, ack); chk_val("rst_ptr_ack", ack, 1);
    write_byte(8'h33, 1'b1, ack); chk_val("rst_data_ack", ack, 1);
    wt(4);
    chk_val("in_rst_sda_oe", sda_oe, 0);
    rst   = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wt(20);

    i2c_start;
    write_byte(8'h84, 1'b0, ack); chk_val("post_addr_ack", ack, 1);
    write_byte(8'h05, 1'b0, ack); chk_val("post_ptr_ack", ack, 1);
    write_byte(8'h0A, 1'b0, ack); chk_val("post_data_ack", ack, 1);
    i2c_stop;
    exp_d = '{1, 20, 40, 60, 80, 10, 200, 255};
    check_duties("post_rst");

`ifdef I2C_PWM_READBACK_EN
    i2c_start;
    write_byte(8'h84, 1'b0, ack); chk_val("rb_waddr_ack", ack, 1);
    write_byte(8'h06, 1'b0, ack); chk_val("rb_ptr_ack", ack, 1);
    i2c_start;
    write_byte(8'h85, 1'b0, ack); chk_val("rb_raddr_ack", ack, 1);
    read_byte(1'b1, rd); chk_val("rb_byte0", rd, 8'hC8);
    read_byte(1'b0, rd); chk_val("rb_byte1", rd, 8'hFF);
    read_byte(1'b0, rd); chk_val("rb_ignore", rd, 8'hFF);
    chk_val("rb_ignore_sda_oe", sda_oe, 0);
    i2c_stop;
`else
    i2c_start;
    write_byte(8'h85, 1'b0, ack); chk_val("rd_addr_nack", ack, 0);
    write_byte(8'h00, 1'b0, ack); chk_val("rd_follow_nack", ack, 0);
    i2c_stop;
`endif
    chk_val("end_sda_oe", sda_oe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_pwm_ctrl.md
Name: i2c_pwm_ctrl

Overview:
- 8-channel LED PWM controller with an I2C slave register interface.
- Everything runs on the system clock `clk`. SCL and SDA are oversampled; SCL is never used as a clock.
- A shared prescaler produces PWM ticks. Eight 8-bit duty registers, written over I2C, set the duty cycle of eight PWM outputs.
- Sits between the board I2C pins and the LED PMOD.

Parameters:
- I2C_ADDR, 7'h42, 7-bit slave address.
- DIVIDER, 1200, clk cycles per PWM tick (must be ≥ 2).

Ports:
- clk  in  1  system clock (12 MHz nominal); sole clock.
- rst  in  1  asynchronous, active-high reset.
- scl_i  in  1  raw SCL pin level.
- sda_i  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- pwm_out  out  8  PWM outputs, bit n = channel n.

Behaviour:
- Reset (async assert; deassert synchronous to clk):
  - sda_oe = 0, pwm_out = 0, prescaler = 0, PWM counter = 0, FSM = IDLE, pointer = 0.
  - Duty/shadow registers 0..7 = 1, 20, 40, 60, 80, 100, 200, 255.
  - Reset mid-transaction aborts the transaction silently.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-FF synchronizer, then a 3-sample majority filter.
  - Edges are detected on the filtered values.
  - Detection latency is ≤ 5 clk; SCL high/low phases must exceed 8 clk.
- Bus conditions:
  - START/repeated START: SDA falls while SCL high. Always resets bit count and goes to ADDR from any state.
  - STOP: SDA rises while SCL high. Goes to IDLE from any state and releases SDA.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Bit sampling: bits are sampled on SCL rising edge, MSB first. sda_oe changes only on SCL falling edge.
- ADDR:
  - After 8 bits, compare byte[7:1] with I2C_ADDR.
  - Match with W (bit0 = 0): ACK (sda_oe = 1 from the 8th falling edge to the 9th falling edge), then go to REG.
  - Mismatch: no ACK, go to IGNORE until START/STOP.
  - Read (R) handling is defined under Optional Feature.
- REG:
  - The byte sets pointer = byte[2:0]; upper bits are ignored. ACK, then WDATA.
- WDATA:
  - Each byte is written to duty[pointer], then pointer = pointer + 1 mod 8 (7 wraps to 0). ACK every byte.
  - Byte count per transaction is unlimited.
- No clock stretching; sda_oe is never asserted while SCL is high, except during an ACK bit or a read data bit.
- Prescaler: counts 0..DIVIDER-1; `tick` is asserted for one clk when the count wraps to 0.
- PWM:
  - Shared 8-bit counter advances on each tick, 0..254, then wraps to 0 (period 255 ticks).
  - On the tick that wraps to 0, shadow[n] ← duty[n] for all n. A new duty takes effect at the next period start; there are no glitches mid-period.
  - pwm_out[n] = (counter < shadow[n]), registered (1 clk latency).
  - Duty 0 → constantly 0; duty 255 → constantly 1; duty d → high for d ticks per 255.
- A duty write arriving on the same clk as a shadow load goes to duty[] only; it is shadowed at the following period.

Optional Feature:
- Macro I2C_PWM_READBACK_EN.
- Defined:
  - An address match with R: ACK, enter RDATA.
  - RDATA drives duty[pointer] MSB first: sda_oe = ~bit, updated on SCL falling edges.
  - After each byte, pointer increments mod 8, and SDA is released for the master's ACK.
  - Master ACK → next byte; master NACK → IGNORE.
- Undefined: R addresses are NACKed and the FSM goes to IGNORE; RDATA/RDATA_ACK logic is absent.

Decomposition:
- Package i2c_pwm_pkg: NUM_CH = 8, PWM_PERIOD = 255, FSM state enum, reset-duty constant array.
- Sub-module i2c_pwm_channel (shadow register + compare + output flop), instantiated 8×.
- I2C FSM, prescaler and shared counter live in the top.

Test Plan:
- Reset release → pwm_out[7] constantly 1; pwm_out[0] high for 1 of every 255 ticks; pwm_out[6] high for 200 ticks/period; sda_oe = 0.
- Write address 0x84 (I2C_ADDR 0x42, W), pointer 0x03, data 0x00, 0x80 → ACKs on all 4 bytes. From the next period: ch3 constantly 0, ch4 high for 128 ticks per period.
- Pointer 0x07, data 0x10, 0x20 → pointer wraps: duty[7] = 0x10, duty[0] = 0x20.
- Address 0x86 (wrong) → no ACK (sda_oe stays 0); following bytes ignored; duties unchanged.
- Assert rst mid-data-byte → sda_oe = 0 immediately; duties back to defaults; next START handled normally.
- With I2C_PWM_READBACK_EN: write pointer 0x06, repeated START, address 0x85 → reads 0xC8, 0xFF, then master NACK → IGNORE.
